alu_ctrl_sequencer: RTL and testbench
=====================================

# alu_ctrl_sequencer

Hard-wired control sequencer for the phase-1 datapath. It steps the fetch (T0–T2) and register-to-register ALU execute (T3–T5) cycles in hardware instead of a bench, and drives the datapath's strobe inputs: PCout, Zlowout, MARin, Zin, IncPC, Read, MDRin, MDRout, IRin, Yin, PCin and the ALU op code. It sits directly upstream of the datapath and consumes the IR value the datapath latches.

## Interface
- OPW, 5, opcode field width (IR[31:27])
- Clock  in  1  system clock, all state changes on rising edge
- Reset_n  in  1  synchronous, active-low reset, sampled on rising edge of Clock
- IR  in  32  instruction register contents from datapath
- Stop  in  1  request halt at next instruction boundary
- PCout, Zlowout, ZHighout, MDRout  out  1 each  bus-drive strobes
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register-load strobes
- IncPC, Read  out  1 each  PC-increment select / memory read
- Gra, Grb, Grc  out  1 each  register-field select to select-and-encode logic (IR[26:23], [22:19], [18:15])
- Rin, Rout  out  1 each  general-register load / drive, qualified by Gr*
- ALU_op  out  5  operation to ALU, equals IR opcode in T4, else 0
- Run  out  1  high while sequencing, low in HALT
- Illegal  out  1  one-cycle pulse on undecodable opcode

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, HALT. State register 3 bits min; outputs decoded combinationally from state (Moore) plus latched opcode.
- RST → T0 on first edge with Reset_n=1. T0→T1→T2→T3 unconditionally.
- Opcode latched at end of T2 (IR valid after IRin edge is sampled on T3 entry; latch IR[31:27] on T3 entry edge into op_q).
- Opcode classes:
  - 3-reg ALU: 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or.
  - 2-reg ALU: 10001 neg, 10010 not.
  - 11010 nop: T3 → T0 directly, no strobes in T3.
  - 11011 halt: T3 → HALT.
  - Anything else: Illegal=1 during T3, T3 → T0, no register write.
- Strobes per state:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3 (ALU classes): Grb, Rout, Yin.
  - T4: 3-reg: Grc, Rout; 2-reg: Grb, Rout. Both: ALU_op=op_q, Zin.
  - T5: Zlowout, Gra, Rin.
- T5 → HALT if Stop=1 at that edge, else T0. Stop ignored in other states (instruction always completes).
- HALT: all strobes 0, Run=0; leaves only via Reset_n=0.
- At most one bus driver (PCout, Zlowout, ZHighout, MDRout, Rout) asserted in any state; ZHighout constant 0 in this block.

## Timing
- Reset: Reset_n=0 at a rising edge forces RST next cycle regardless of current state, including mid-instruction; no partial writes complete after that edge. In RST all strobes 0, ALU_op=0, Run=0, Illegal=0, op_q=0.
- Run=1 in T0–T5.
- Each state lasts exactly one Clock cycle; strobes valid for whole cycle, destination registers capture on the closing edge.
- ALU instruction: 6 cycles T0 to next T0. nop / illegal: 4 cycles. Halt: 4 cycles to HALT.
- Illegal is high only during the T3 cycle of the offending instruction.
- Stop and Reset_n asserted same edge: reset wins.
- IR changes outside T2→T3 edge have no effect on current instruction.

## Test plan
- Reset held 3 cycles, release → every output 0 during reset, Run=0; first cycle after release RST, then T0 with PCout=MARin=IncPC=Zin=1.
- IR=0x4A920000 (and, Ra=5, Rb=2, Rc=4) → T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with ALU_op=01001, T5 Zlowout/Gra/Rin, T0 six cycles after previous T0.
- IR=0x88900000 (neg, Ra=1, Rb=2) → T4 asserts Grb not Grc, ALU_op=10001; Grc never asserted.
- IR=0xF8000000 (opcode 11111) → Illegal pulse exactly 1 cycle in T3, no Rin, next T0 four cycles after previous T0; halt opcode 0xD8000000 → HALT, Run=0, strobes 0 indefinitely.
- Stop=1 raised during T2 of an add → instruction completes with T5 Rin, then HALT; Stop raised then dropped before T5 → no halt.
- Reset_n=0 during T4 → next cycle RST, Zin/Rin never asserted afterwards, sequence restarts at T0; scoreboard checks one bus driver per cycle throughout.

Source files
------------

// File: rtl/alu_ctrl_sequencer.sv
// Hard-wired fetch/execute control sequencer for the phase-1 datapath.
// Moore FSM stepping T0..T5; strobes decoded from state plus the opcode latched on T3 entry.
module alu_ctrl_sequencer #(
  parameter int unsigned OPW = 5
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic [31:0]    IR,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] ALU_op,
  output logic           Run,
  output logic           Illegal
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [2:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [OPW-1:0] op_q;
  logic           is_three;
  logic           is_two;
  logic           is_nop;
  logic           is_halt;

  // Register fields are consumed by the downstream select-and-encode logic, not here.
  logic unused_ir;
  assign unused_ir = ^IR[31-OPW:0];

  // State register; opcode captured on the T2 -> T3 edge only.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= S_RST;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T2) begin
        op_q <= IR[31 -: OPW];
      end
    end
  end

  // Opcode class decode of the latched opcode.
  always_comb begin
    is_three = 1'b0;
    is_two   = 1'b0;
    is_nop   = 1'b0;
    is_halt  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:   is_three = 1'b1;
      OP_NEG, OP_NOT:                  is_two   = 1'b1;
      OP_NOP:                          is_nop   = 1'b1;
      OP_HALT:                         is_halt  = 1'b1;
      default: ;
    endcase
  end

  // Next-state and Moore strobe decode.
  always_comb begin
    state_nxt = state;
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    ZHighout  = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    Zin       = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    ALU_op    = '0;
    Run       = 1'b0;
    Illegal   = 1'b0;
    case (state)
      S_RST: begin
        state_nxt = S_T0;
      end
      S_T0: begin
        Run       = 1'b1;
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        Zin       = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Run       = 1'b1;
        Zlowout   = 1'b1;
        PCin      = 1'b1;
        Read      = 1'b1;
        MDRin     = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        Run       = 1'b1;
        MDRout    = 1'b1;
        IRin      = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        Run = 1'b1;
        if (is_three || is_two) begin
          Grb       = 1'b1;
          Rout      = 1'b1;
          Yin       = 1'b1;
          state_nxt = S_T4;
        end else if (is_nop) begin
          state_nxt = S_T0;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          Illegal   = 1'b1;
          state_nxt = S_T0;
        end
      end
      S_T4: begin
        Run       = 1'b1;
        Grc       = is_three;
        Grb       = is_two;
        Rout      = 1'b1;
        Zin       = 1'b1;
        ALU_op    = op_q;
        state_nxt = S_T5;
      end
      S_T5: begin
        Run       = 1'b1;
        Zlowout   = 1'b1;
        Gra       = 1'b1;
        Rin       = 1'b1;
        state_nxt = Stop ? S_HALT : S_T0;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Randomized bench for alu_ctrl_sequencer; expected strobes come from a per-instruction
// cycle table built from the opcode class rules.
module tb_alu_ctrl_sequencer;

  logic        Clock;
  logic        Reset_n;
  logic [31:0] IR;
  logic        Stop;
  logic        PCout, Zlowout, ZHighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, Illegal;
  logic [4:0]  ALU_op;

  alu_ctrl_sequencer #(.OPW(5)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .ALU_op(ALU_op), .Run(Run), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [23:0] M_PCOUT  = 24'(1) << 23;
  localparam logic [23:0] M_ZLOW   = 24'(1) << 22;
  localparam logic [23:0] M_MDROUT = 24'(1) << 20;
  localparam logic [23:0] M_MARIN  = 24'(1) << 19;
  localparam logic [23:0] M_ZIN    = 24'(1) << 18;
  localparam logic [23:0] M_PCIN   = 24'(1) << 17;
  localparam logic [23:0] M_MDRIN  = 24'(1) << 16;
  localparam logic [23:0] M_IRIN   = 24'(1) << 15;
  localparam logic [23:0] M_YIN    = 24'(1) << 14;
  localparam logic [23:0] M_INCPC  = 24'(1) << 13;
  localparam logic [23:0] M_READ   = 24'(1) << 12;
  localparam logic [23:0] M_GRA    = 24'(1) << 11;
  localparam logic [23:0] M_GRB    = 24'(1) << 10;
  localparam logic [23:0] M_GRC    = 24'(1) << 9;
  localparam logic [23:0] M_RIN    = 24'(1) << 8;
  localparam logic [23:0] M_ROUT   = 24'(1) << 7;
  localparam logic [23:0] M_RUN    = 24'(1) << 1;
  localparam logic [23:0] M_ILL    = 24'(1) << 0;

  logic [23:0] obs;
  assign obs = {PCout, Zlowout, ZHighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run, Illegal};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the whole cycle sequence of one instruction, from its opcode class.
  function automatic void build(input logic [31:0] ir, output bit alu);
    logic [4:0] op;
    bit three, two;
    op    = ir[31:27];
    three = (op >= 5'd3) && (op <= 5'd10);
    two   = (op == 5'd17) || (op == 5'd18);
    alu   = three || two;
    exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
    exp_q.push_back(M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN);
    exp_q.push_back(M_MDROUT | M_IRIN | M_RUN);
    if (alu) begin
      exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN);
      exp_q.push_back((three ? M_GRC : M_GRB) | M_ROUT | M_ZIN | M_RUN | (24'(op) << 2));
      exp_q.push_back(M_ZLOW | M_GRA | M_RIN | M_RUN);
    end else if (op == 5'd26 || op == 5'd27) begin
      exp_q.push_back(M_RUN);
    end else begin
      exp_q.push_back(M_RUN | M_ILL);
    end
  endfunction

  task automatic sample(input string tag, input logic [23:0] e);
    int nb;
    nb = int'(PCout) + int'(Zlowout) + int'(ZHighout) + int'(MDRout) + int'(Rout);
    check(tag, 32'(obs), 32'(e));
    check("one_bus_driver", 32'(nb <= 1), 32'd1);
  endtask

  task automatic drive_noise();
    IR   = $urandom;
    Stop = 1'($urandom % 2);
  endtask

  // Called at a negedge; leaves the DUT in RST with reset released for the next edge.
  task automatic do_reset(input int n);
    Reset_n = 1'b0;
    drive_noise();
    repeat (n) begin
      @(posedge Clock);
      @(negedge Clock);
      sample("reset_outputs", 24'd0);
    end
    Reset_n = 1'b1;
    drive_noise();
  endtask

  task automatic run_instr(input logic [31:0] ir, input bit stop_t5, input int abort_at,
                           output bit halted);
    bit alu;
    int n;
    halted = 1'b0;
    exp_q.delete();
    build(ir, alu);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      sample($sformatf("op%02h_cyc%0d", ir[31:27], i), exp_q[i]);
      drive_noise();
      if (i == 2) IR = ir;
      if (alu && i == 5) Stop = stop_t5;
      if (i == abort_at) begin
        Reset_n = 1'b0;
        Stop    = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        sample("abort_rst", 24'd0);
        Reset_n = 1'b1;
        drive_noise();
        return;
      end
    end
    halted = (ir[31:27] == 5'd27) || (alu && stop_t5);
  endtask

  task automatic check_halt(input int k);
    repeat (k) begin
      @(posedge Clock);
      @(negedge Clock);
      sample("halt_idle", 24'd0);
      drive_noise();
    end
  endtask

  logic [4:0] legal_ops[12] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                5'd17, 5'd18, 5'd26, 5'd27};

  initial begin
    bit h;
    logic [4:0] op;
    logic [31:0] ir;
    int ab;
    Reset_n = 1'b0;
    Stop    = 1'b0;
    IR      = '0;
    do_reset(3);

    run_instr(32'h4A92_0000, 1'b0, -1, h);   // and
    run_instr(32'h8890_0000, 1'b0, -1, h);   // neg
    run_instr(32'hF800_0000, 1'b0, -1, h);   // illegal
    run_instr(32'hD000_0000, 1'b0, -1, h);   // nop
    run_instr(32'h1A92_0000, 1'b1, -1, h);   // add with Stop at T5
    check("stop_halts", 32'(h), 32'd1);
    check_halt(4);
    do_reset(1);
    run_instr(32'h1A92_0000, 1'b0, 4, h);    // reset during T4
    run_instr(32'h2A92_0000, 1'b1, 5, h);    // reset and Stop on same edge
    run_instr(32'hD800_0000, 1'b0, -1, h);   // halt
    check_halt(6);
    do_reset(2);

    for (int t = 0; t < 120; t++) begin
      if ($urandom % 4 == 0) op = 5'($urandom);
      else op = legal_ops[$urandom % 12];
      ir = {op, 27'($urandom)};
      ab = ($urandom % 10 == 0) ? int'($urandom % 6) : -1;
      run_instr(ir, ($urandom % 8) == 0, ab, h);
      if (h) begin
        check_halt(1 + int'($urandom % 3));
        do_reset(1 + int'($urandom % 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
